// File: rtl/gray_counter_updown.sv
// gray_counter_updown
// Up/down Gray-code counter with asynchronous active-low reset, synchronous
// clear and parallel load, combinational terminal count and a registered
// wrap pulse. The binary count is the only real state. The Gray output is
// registered from the same next-state value, so both outputs change on the
// same edge.
//
// Build option: defining GRAY_CNT_SATURATE_EN adds the Saturate_in port.
// With that input high, a step that would wrap holds the count at its limit
// instead.
module gray_counter_updown #(
   parameter int COUNTER_WIDTH = 4,
   parameter int CLEAR_VALUE   = 0
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     Clear_in,
   input  logic                     Load_in,
   input  logic [COUNTER_WIDTH-1:0] LoadValue_in,
   input  logic                     Enable_in,
   input  logic                     Down_in,
`ifdef GRAY_CNT_SATURATE_EN
   input  logic                     Saturate_in,
`endif
   output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
   output logic [COUNTER_WIDTH-1:0] GrayCount_out,
   output logic                     TerminalCount_out,
   output logic                     Wrap_out
);

   localparam logic [COUNTER_WIDTH-1:0] CLEAR_BIN = COUNTER_WIDTH'(CLEAR_VALUE);
   localparam logic [COUNTER_WIDTH-1:0] ALL_ONES  = '1;
   localparam logic [COUNTER_WIDTH-1:0] ALL_ZEROS = '0;

   // Reject parameter sets that cannot work before any logic is built.
   if (COUNTER_WIDTH < 2) begin : g_width_check
      $error("gray_counter_updown: COUNTER_WIDTH must be at least 2");
   end
   if ((CLEAR_VALUE < 0) ||
       ((COUNTER_WIDTH < 31) && (CLEAR_VALUE >= (1 << COUNTER_WIDTH)))) begin : g_clear_check
      $error("gray_counter_updown: CLEAR_VALUE does not fit in COUNTER_WIDTH bits");
   end

   // Binary to reflected Gray code.
   function automatic logic [COUNTER_WIDTH-1:0] to_gray(input logic [COUNTER_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // True when the next step in the given direction would wrap.
   function automatic logic at_limit(input logic [COUNTER_WIDTH-1:0] bin, input logic down);
      return down ? (bin == ALL_ZEROS) : (bin == ALL_ONES);
   endfunction

   // One modular step. Carry and borrow are discarded.
   function automatic logic [COUNTER_WIDTH-1:0] step(input logic [COUNTER_WIDTH-1:0] bin,
                                                     input logic down);
      return down ? (bin - 1'b1) : (bin + 1'b1);
   endfunction

   // Step with optional saturation. When holding, the count stays at the limit.
   function automatic logic [COUNTER_WIDTH-1:0] saturate_step(input logic [COUNTER_WIDTH-1:0] bin,
                                                              input logic down,
                                                              input logic sat);
      if (sat && at_limit(bin, down)) begin
         return bin;
      end
      return step(bin, down);
   endfunction

   logic [COUNTER_WIDTH-1:0] count_q;
   logic [COUNTER_WIDTH-1:0] gray_q;
   logic                     wrap_q;
   logic [COUNTER_WIDTH-1:0] count_d;
   logic                     wrap_d;
   logic                     sat_mode;

`ifdef GRAY_CNT_SATURATE_EN
   assign sat_mode = Saturate_in;
`else
   assign sat_mode = 1'b0;
`endif

   // Next-state selection. Priority is clear, then load, then enable, then hold.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (Clear_in) begin
         count_d = CLEAR_BIN;
      end else if (Load_in) begin
         count_d = LoadValue_in;
      end else if (Enable_in) begin
         count_d = saturate_step(count_q, Down_in, sat_mode);
         wrap_d  = at_limit(count_q, Down_in) && !sat_mode;
      end
   end

   // Count, Gray and wrap registers. Gray comes from count_d, so it has no skew against the binary count.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count_q <= CLEAR_BIN;
         gray_q  <= to_gray(CLEAR_BIN);
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         gray_q  <= to_gray(count_d);
         wrap_q  <= wrap_d;
      end
   end

   assign BinaryCount_out   = count_q;
   assign GrayCount_out     = gray_q;
   assign TerminalCount_out = at_limit(count_q, Down_in);
   assign Wrap_out          = wrap_q;

endmodule

// File: tb/tb_gray_counter_updown.sv
// Scoreboard bench for gray_counter_updown (COUNTER_WIDTH=4, CLEAR_VALUE=5).
// The driver applies one directed vector per cycle on the falling edge and
// queues the hand-computed outputs expected after the next rising edge. The
// monitor pops one entry per rising edge and compares.
module tb_gray_counter_updown;

   typedef struct {
      logic [3:0] bin;
      logic [3:0] gray;
      logic       tc;
      logic       wrap;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       load;
   logic [3:0] load_value;
   logic       enable;
   logic       down;
`ifdef GRAY_CNT_SATURATE_EN
   logic       sat;
`endif
   logic [3:0] bin;
   logic [3:0] gray;
   logic       tc;
   logic       wrap;

   int   checks   = 0;
   int   failures = 0;
   int   vec_idx  = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   // Hand-written 4-bit Gray table, indexed by binary value.
   logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   gray_counter_updown #(
      .COUNTER_WIDTH(4),
      .CLEAR_VALUE  (5)
   ) dut (
      .Clk              (clk),
      .Reset_n          (rst_n),
      .Clear_in         (clear),
      .Load_in          (load),
      .LoadValue_in     (load_value),
      .Enable_in        (enable),
      .Down_in          (down),
`ifdef GRAY_CNT_SATURATE_EN
      .Saturate_in      (sat),
`endif
      .BinaryCount_out  (bin),
      .GrayCount_out    (gray),
      .TerminalCount_out(tc),
      .Wrap_out         (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic l, input logic [3:0] lv,
                        input logic en, input logic dn,
                        input logic [3:0] eb, input logic [3:0] eg,
                        input logic etc, input logic ew);
      exp_t e;
      @(negedge clk);
      rst_n      = r;
      clear      = c;
      load       = l;
      load_value = lv;
      enable     = en;
      down       = dn;
      e.bin  = eb;
      e.gray = eg;
      e.tc   = etc;
      e.wrap = ew;
      e.idx  = vec_idx;
      vec_idx++;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry is consumed per rising edge once the driver has queued it.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk($sformatf("bin[%0d]", mon_e.idx), {28'd0, bin}, {28'd0, mon_e.bin});
         chk($sformatf("gray[%0d]", mon_e.idx), {28'd0, gray}, {28'd0, mon_e.gray});
         chk($sformatf("tc[%0d]", mon_e.idx), {31'd0, tc}, {31'd0, mon_e.tc});
         chk($sformatf("wrap[%0d]", mon_e.idx), {31'd0, wrap}, {31'd0, mon_e.wrap});
      end
   end

   initial begin
      logic [3:0] b;
      rst_n      = 1'b1;
      clear      = 1'b0;
      load       = 1'b0;
      load_value = 4'h0;
      enable     = 1'b0;
      down       = 1'b0;
`ifdef GRAY_CNT_SATURATE_EN
      sat        = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #1;
      chk("reset_bin_async", {28'd0, bin}, 32'h5);
      chk("reset_gray_async", {28'd0, gray}, 32'h7);
      chk("reset_wrap_async", {31'd0, wrap}, 32'h0);

      // Reset held while enable toggles: outputs stay at 5 / 7.
      drive(0, 0, 0, 4'h0, 1, 0, 4'h5, 4'h7, 0, 0);
      drive(0, 0, 0, 4'h0, 0, 0, 4'h5, 4'h7, 0, 0);
      drive(0, 0, 0, 4'h0, 1, 1, 4'h5, 4'h7, 0, 0);
      drive(0, 1, 1, 4'h3, 1, 0, 4'h5, 4'h7, 0, 0);
      // Release and idle.
      drive(1, 0, 0, 4'h0, 0, 0, 4'h5, 4'h7, 0, 0);

      // Up sweep from 0 for 17 steps; the wrap pulse shows with binary 0.
      drive(1, 0, 1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);
      for (int k = 1; k <= 17; k++) begin
         b = 4'(k);
         drive(1, 0, 0, 4'h0, 1, 0, b, gtab[b], (b == 4'hF), (k == 16));
      end

      // Down wrap: 1, 0, F, E.
      drive(1, 0, 1, 4'h1, 0, 1, 4'h1, 4'h1, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'hF, 4'h8, 0, 1);
      drive(1, 0, 0, 4'h0, 1, 1, 4'hE, 4'h9, 0, 0);

      // Priority at the up limit: clear beats load and enable, load beats enable.
      drive(1, 0, 1, 4'hF, 0, 0, 4'hF, 4'h8, 1, 0);
      drive(1, 1, 1, 4'hA, 1, 0, 4'h5, 4'h7, 0, 0);
      drive(1, 0, 1, 4'hF, 0, 0, 4'hF, 4'h8, 1, 0);
      drive(1, 0, 1, 4'hA, 1, 0, 4'hA, 4'hF, 0, 0);
      // Idle hold, then direction changes between steps.
      drive(1, 0, 0, 4'h0, 0, 0, 4'hA, 4'hF, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 0, 4'hB, 4'hE, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'hA, 4'hF, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'h9, 4'hD, 0, 0);

`ifdef GRAY_CNT_SATURATE_EN
      // Saturating up at F, then stepping down; saturating down at 0.
      sat = 1'b1;
      drive(1, 0, 1, 4'hE, 0, 0, 4'hE, 4'h9, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1, 0);
      drive(1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1, 0);
      drive(1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'hE, 4'h9, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'hD, 4'hB, 0, 0);
      drive(1, 0, 1, 4'h0, 0, 1, 4'h0, 4'h0, 1, 0);
      drive(1, 0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1, 0);
      sat = 1'b0;
`endif

      // Asynchronous reset between edges while counting at 9.
      drive(1, 0, 1, 4'h8, 0, 0, 4'h8, 4'hC, 0, 0);
      drive(1, 0, 0, 4'h0, 1, 0, 4'h9, 4'hD, 0, 0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_bin", {28'd0, bin}, 32'h5);
      chk("midreset_gray", {28'd0, gray}, 32'h7);
      chk("midreset_wrap", {31'd0, wrap}, 32'h0);
      #1 rst_n = 1'b1;
      // Enable is still high and up, so the next edge counts 5 -> 6.
      mon_e.bin  = 4'h6;
      mon_e.gray = 4'h5;
      mon_e.tc   = 1'b0;
      mon_e.wrap = 1'b0;
      mon_e.idx  = vec_idx;
      vec_idx++;
      exp_q.push_back(mon_e);
      drive(1, 0, 0, 4'h0, 1, 0, 4'h7, 4'h4, 0, 0);
      drive(1, 0, 0, 4'h0, 0, 0, 4'h7, 4'h4, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
